// File: rtl/anita3_readout_pkg.sv
// Shared types and defaults for the ANITA3 event readout controller.
package anita3_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_CLR1   = 3'd3,
    ST_GAP    = 3'd4,
    ST_CLR2   = 3'd5,
    ST_SETTLE = 3'd6
  } state_e;

  localparam logic [7:0] HDR_TAG       = 8'hA3;
  localparam int         NWORDS_DEF    = 64;
  localparam int         CLEAR_GAP_DEF = 2;
  localparam int         SETTLE_DEF    = 3;

endpackage

// File: rtl/anita3_readout_skid.sv
// Two-entry 33-bit (last + data) FIFO that owns the outbound stream registers.
// Stream handshake: a beat transfers on a clock edge where m_valid_o and m_ready_i
// are both high; while m_valid_o is high and m_ready_i low, data/last stay frozen.
module anita3_readout_skid (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        push_i,
  input  logic [31:0] push_dat_i,
  input  logic        push_last_i,
  input  logic        m_ready_i,
  output logic [31:0] m_dat_o,
  output logic        m_last_o,
  output logic        m_valid_o,
  output logic        full_o,
  output logic        afull_o
);

  logic [32:0] head_q, tail_q;
  logic [1:0]  cnt_q;
  logic        pop;

  assign pop       = (cnt_q != 2'd0) && m_ready_i;
  assign m_valid_o = (cnt_q != 2'd0);
  assign m_last_o  = head_q[32];
  assign m_dat_o   = head_q[31:0];
  assign full_o    = (cnt_q == 2'd2);
  assign afull_o   = (cnt_q != 2'd0);

  // The head register is the output, so it only changes on pop or when empty.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push_i) begin
            head_q <= {push_last_i, push_dat_i};
            cnt_q  <= 2'd1;
          end
        end
        2'd1: begin
          if (push_i && pop) begin
            head_q <= {push_last_i, push_dat_i};
          end else if (pop) begin
            cnt_q  <= 2'd0;
          end else if (push_i) begin
            tail_q <= {push_last_i, push_dat_i};
            cnt_q  <= 2'd2;
          end
        end
        2'd2: begin
          if (pop) begin
            head_q <= tail_q;
            if (push_i) tail_q <= {push_last_i, push_dat_i};
            else        cnt_q  <= 2'd1;
          end
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/anita3_event_readout.sv
// Read-side controller: streams one buffered event (header + NWORDS words) and
// retires the buffer with a two-pulse clear followed by a settle window.
module anita3_event_readout
  import anita3_readout_pkg::*;
#(
  parameter int NWORDS    = NWORDS_DEF,
  parameter int CLEAR_GAP = CLEAR_GAP_DEF,
  parameter int SETTLE    = SETTLE_DEF
) (
  input  logic                      clk33_i,
  input  logic                      rst_n_i,
  input  logic                      buf_ready_i,
  input  logic                      read_buffer_i,
  output logic [$clog2(NWORDS)-1:0] event_rd_addr_o,
  input  logic [31:0]               event_rd_dat_i,
  output logic                      clear_evt_o,
  output logic [31:0]               m_dat_o,
  output logic                      m_valid_o,
  input  logic                      m_ready_i,
  output logic                      m_last_o,
  output logic                      busy_o,
  output logic [15:0]               evt_count_o,
  output logic [2:0]                dbg_state_o
);

  localparam int AW = $clog2(NWORDS);

  state_e         state_q;
  logic [AW-1:0]  addr_q;
  logic           pend_q, pend_last_q;
  logic [7:0]     tmr_q;
  logic           clr_q, busy_q;
  logic [15:0]    evt_cnt_q;

  logic           start, pop, push, push_last, can_issue, issue;
  logic [31:0]    push_dat;
  logic           skid_full, skid_afull;

  assign start     = (state_q == ST_IDLE) && buf_ready_i;
  assign pop       = m_valid_o && m_ready_i;
  assign push      = start || pend_q;
  assign push_dat  = start ? {HDR_TAG, 7'b0, read_buffer_i, evt_cnt_q} : event_rd_dat_i;
  assign push_last = start ? 1'b0 : pend_last_q;

  // An address may be committed only if the skid is guaranteed a free slot when
  // its data lands next cycle, assuming no pop on that cycle.
  assign can_issue = skid_full  ? (pop && !push) :
                     skid_afull ? (pop || !push) : 1'b1;
  assign issue     = start || ((state_q == ST_READ) && can_issue);

  // Address 0 is already presented in IDLE, so the start edge commits word 0.
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      tmr_q       <= '0;
      clr_q       <= 1'b0;
      busy_q      <= 1'b0;
      evt_cnt_q   <= '0;
    end else begin
      clr_q       <= 1'b0;
      pend_q      <= issue;
      pend_last_q <= issue && (addr_q == AW'(NWORDS - 1));
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= addr_q + AW'(1);
            busy_q  <= 1'b1;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          if (can_issue) begin
            if (addr_q == AW'(NWORDS - 1)) begin
              addr_q  <= '0;
              state_q <= ST_DRAIN;
            end else begin
              addr_q  <= addr_q + AW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (pop && m_last_o) begin
            clr_q   <= 1'b1;
            state_q <= ST_CLR1;
          end
        end
        ST_CLR1: begin
          tmr_q   <= '0;
          state_q <= ST_GAP;
        end
        ST_GAP: begin
          if (tmr_q == 8'(CLEAR_GAP - 1)) begin
            clr_q   <= 1'b1;
            state_q <= ST_CLR2;
          end else begin
            tmr_q   <= tmr_q + 8'd1;
          end
        end
        ST_CLR2: begin
          evt_cnt_q <= evt_cnt_q + 16'd1;
          tmr_q     <= '0;
          state_q   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (tmr_q == 8'(SETTLE - 1)) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tmr_q   <= tmr_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  anita3_readout_skid u_skid (
    .clk_i       (clk33_i),
    .rst_n_i     (rst_n_i),
    .push_i      (push),
    .push_dat_i  (push_dat),
    .push_last_i (push_last),
    .m_ready_i   (m_ready_i),
    .m_dat_o     (m_dat_o),
    .m_last_o    (m_last_o),
    .m_valid_o   (m_valid_o),
    .full_o      (skid_full),
    .afull_o     (skid_afull)
  );

  assign event_rd_addr_o = addr_q;
  assign clear_evt_o     = clr_q;
  assign busy_o          = busy_q;
  assign evt_count_o     = evt_cnt_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_anita3_event_readout.sv
// Self-checking bench for anita3_event_readout: event-level reference model with
// a scoreboard queue of expected beats, plus timing and clear-pulse checks.
module tb_anita3_event_readout;

  localparam int NW  = 64;
  localparam int GAP = 2;
  localparam int STL = 3;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        buf_ready_i = 1'b0;
  logic        read_buffer_i = 1'b0;
  logic [5:0]  event_rd_addr_o;
  logic [31:0] event_rd_dat_i = '0;
  logic        clear_evt_o;
  logic [31:0] m_dat_o;
  logic        m_valid_o;
  logic        m_ready_i = 1'b0;
  logic        m_last_o;
  logic        busy_o;
  logic [15:0] evt_count_o;
  logic [2:0]  dbg_state_o;

  anita3_event_readout #(.NWORDS(NW), .CLEAR_GAP(GAP), .SETTLE(STL)) dut (
    .clk33_i         (clk),
    .rst_n_i         (rst_n_i),
    .buf_ready_i     (buf_ready_i),
    .read_buffer_i   (read_buffer_i),
    .event_rd_addr_o (event_rd_addr_o),
    .event_rd_dat_i  (event_rd_dat_i),
    .clear_evt_o     (clear_evt_o),
    .m_dat_o         (m_dat_o),
    .m_valid_o       (m_valid_o),
    .m_ready_i       (m_ready_i),
    .m_last_o        (m_last_o),
    .busy_o          (busy_o),
    .evt_count_o     (evt_count_o),
    .dbg_state_o     (dbg_state_o)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  int tests_run = 0;
  int fail_cnt  = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer RAM with one-cycle synchronous read.
  logic [31:0] mem [NW];
  always @(posedge clk) event_rd_dat_i <= mem[event_rd_addr_o];

  int ready_mode = 0;  // 0: always ready, 1: random 50 %, 2: stalled
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       m_ready_i = 1'b1;
      1:       m_ready_i = 1'($urandom_range(0, 1));
      default: m_ready_i = 1'b0;
    endcase
  end

  // ---------------- reference model / scoreboard ----------------
  logic [32:0] exp_q[$];
  logic [15:0] model_count = '0;
  logic [32:0] exp_beat;

  int          clr_cnt = 0;
  int          clr_last_cyc = 0, clr_prev_cyc = 0;
  int          hdr_cyc = 0, last_hs_cyc = 0;
  int          beat_idx = 0;
  logic [31:0] hdr_dat = '0;
  bit          prev_stall = 0;
  logic [31:0] prev_dat;
  logic        prev_last;

  always @(negedge clk) begin
    if (!rst_n_i) begin
      prev_stall = 0;
      beat_idx   = 0;
    end else begin
      if (clear_evt_o) begin
        clr_cnt++;
        clr_prev_cyc = clr_last_cyc;
        clr_last_cyc = cyc;
      end
      if (prev_stall) begin
        tests_run++;
        if (!m_valid_o || m_dat_o !== prev_dat || m_last_o !== prev_last) begin
          fail_cnt++;
          $display("FAIL hold_stable: got valid=%0b dat=%h last=%0b, required valid=1 dat=%h last=%0b",
                   m_valid_o, m_dat_o, m_last_o, prev_dat, prev_last);
        end
      end
      if (m_valid_o && m_ready_i) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fail_cnt++;
          $display("FAIL extra_beat: got %h last=%0b, required no beat", m_dat_o, m_last_o);
        end else begin
          exp_beat = exp_q.pop_front();
          if ({m_last_o, m_dat_o} !== exp_beat) begin
            fail_cnt++;
            $display("FAIL beat[%0d]: got last=%0b dat=%h, required last=%0b dat=%h",
                     beat_idx, m_last_o, m_dat_o, exp_beat[32], exp_beat[31:0]);
          end
        end
        if (beat_idx == 0) begin
          hdr_cyc = cyc;
          hdr_dat = m_dat_o;
        end
        last_hs_cyc = cyc;
        if (m_last_o) beat_idx = 0;
        else          beat_idx++;
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_dat   = m_dat_o;
      prev_last  = m_last_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < NW; i++) mem[i] = ramp ? (i * 32'h01010101) : $urandom;
  endtask

  // One event as seen from the host: header, then the NW buffer words, last on the final one.
  task automatic push_expected(input bit rb, input logic [15:0] cnt);
    exp_q.push_back({1'b0, 8'hA3, 7'b0, rb, cnt});
    for (int i = 0; i < NW; i++) exp_q.push_back({(i == NW - 1), mem[i]});
  endtask

  task automatic launch(output bit ok);
    ok = 0;
    buf_ready_i = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (busy_o) ok = 1;
    end
    buf_ready_i = 1'b0;
  endtask

  task automatic wait_done(input int clr_target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (clr_cnt >= clr_target && !busy_o) ok = 1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) step();
    tests_run += 7;
    if (event_rd_addr_o !== 6'd0) begin fail_cnt++; $display("FAIL reset_addr: got %0d, required 0", event_rd_addr_o); end
    if (clear_evt_o !== 1'b0)     begin fail_cnt++; $display("FAIL reset_clear: got %0b, required 0", clear_evt_o); end
    if (m_valid_o !== 1'b0)       begin fail_cnt++; $display("FAIL reset_valid: got %0b, required 0", m_valid_o); end
    if (m_dat_o !== 32'd0)        begin fail_cnt++; $display("FAIL reset_dat: got %h, required 0", m_dat_o); end
    if (m_last_o !== 1'b0)        begin fail_cnt++; $display("FAIL reset_last: got %0b, required 0", m_last_o); end
    if (busy_o !== 1'b0)          begin fail_cnt++; $display("FAIL reset_busy: got %0b, required 0", busy_o); end
    if (evt_count_o !== 16'd0)    begin fail_cnt++; $display("FAIL reset_count: got %0d, required 0", evt_count_o); end
    rst_n_i = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_single();
    bit ok_l, ok_d;
    int c0, clr0;
    ready_mode = 0;
    fill_mem(1);
    read_buffer_i = 1'b1;
    push_expected(1'b1, model_count);
    clr0 = clr_cnt;
    step();
    c0 = cyc;
    launch(ok_l);
    wait_done(clr0 + 2, 300, ok_d);
    model_count++;
    tests_run += 9;
    if (!ok_l || !ok_d) begin fail_cnt++; $display("FAIL single_timeout: got start=%0b done=%0b, required 1 1", ok_l, ok_d); end
    if (hdr_dat !== 32'hA3010000) begin fail_cnt++; $display("FAIL single_header: got %h, required a3010000", hdr_dat); end
    if (hdr_cyc - c0 != 1) begin fail_cnt++; $display("FAIL single_hdr_latency: got %0d, required 1", hdr_cyc - c0); end
    if (last_hs_cyc - hdr_cyc != NW) begin fail_cnt++; $display("FAIL single_burst_len: got %0d, required %0d", last_hs_cyc - hdr_cyc, NW); end
    if (clr_prev_cyc - last_hs_cyc != 1) begin fail_cnt++; $display("FAIL single_clr1_latency: got %0d, required 1", clr_prev_cyc - last_hs_cyc); end
    if (clr_last_cyc - clr_prev_cyc != GAP + 1) begin fail_cnt++; $display("FAIL single_clr_spacing: got %0d, required %0d", clr_last_cyc - clr_prev_cyc, GAP + 1); end
    if (clr_cnt - clr0 != 2) begin fail_cnt++; $display("FAIL single_clr_count: got %0d, required 2", clr_cnt - clr0); end
    if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL single_missing: got %0d beats left, required 0", exp_q.size()); end
    if (evt_count_o !== model_count) begin fail_cnt++; $display("FAIL single_count: got %0d, required %0d", evt_count_o, model_count); end
  endtask

  task automatic test_random();
    bit ok_l, ok_d;
    int clr0, tmo;
    bit rb;
    ready_mode = 1;
    clr0 = clr_cnt;
    tmo = 0;
    for (int e = 0; e < 20; e++) begin
      fill_mem(0);
      rb = 1'($urandom_range(0, 1));
      read_buffer_i = rb;
      push_expected(rb, model_count);
      launch(ok_l);
      read_buffer_i = ~rb;  // must not disturb the event in flight
      wait_done(clr0 + 2 * (e + 1), 1000, ok_d);
      if (!ok_l || !ok_d) tmo++;
      model_count++;
    end
    ready_mode = 0;
    tests_run += 4;
    if (tmo != 0) begin fail_cnt++; $display("FAIL random_timeout: got %0d stuck events, required 0", tmo); end
    if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL random_missing: got %0d beats left, required 0", exp_q.size()); end
    if (clr_cnt - clr0 != 40) begin fail_cnt++; $display("FAIL random_clr_count: got %0d, required 40", clr_cnt - clr0); end
    if (evt_count_o !== model_count) begin fail_cnt++; $display("FAIL random_count: got %0d, required %0d", evt_count_o, model_count); end
  endtask

  task automatic test_stall();
    bit ok_l, ok_d;
    int clr0;
    logic [5:0]  a1, a2;
    logic [31:0] hdr_exp;
    ready_mode = 2;
    step();
    fill_mem(0);
    read_buffer_i = 1'b0;
    hdr_exp = {8'hA3, 7'b0, 1'b0, model_count};
    push_expected(1'b0, model_count);
    clr0 = clr_cnt;
    launch(ok_l);
    repeat (10) step();
    a1 = event_rd_addr_o;
    repeat (90) step();
    a2 = event_rd_addr_o;
    tests_run += 4;
    if (a1 !== a2) begin fail_cnt++; $display("FAIL stall_addr_moving: got %0d then %0d, required equal", a1, a2); end
    if (a2 > 6'd2) begin fail_cnt++; $display("FAIL stall_outstanding: got addr %0d, required <= 2", a2); end
    if (m_valid_o !== 1'b1) begin fail_cnt++; $display("FAIL stall_valid: got %0b, required 1", m_valid_o); end
    if (m_dat_o !== hdr_exp) begin fail_cnt++; $display("FAIL stall_header: got %h, required %h", m_dat_o, hdr_exp); end
    ready_mode = 0;
    wait_done(clr0 + 2, 300, ok_d);
    model_count++;
    tests_run += 3;
    if (!ok_l || !ok_d) begin fail_cnt++; $display("FAIL stall_timeout: got start=%0b done=%0b, required 1 1", ok_l, ok_d); end
    if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL stall_missing: got %0d beats left, required 0", exp_q.size()); end
    if (evt_count_o !== model_count) begin fail_cnt++; $display("FAIL stall_count: got %0d, required %0d", evt_count_o, model_count); end
  endtask

  task automatic test_back_to_back();
    bit ok_c, ok_b, ok_d;
    int clr0, c2;
    ready_mode = 0;
    fill_mem(0);
    push_expected(1'b1, model_count);
    push_expected(1'b0, model_count + 16'd1);
    clr0 = clr_cnt;
    read_buffer_i = 1'b1;
    buf_ready_i = 1'b1;
    repeat (3) step();
    read_buffer_i = 1'b0;  // latched only by the next event
    ok_c = 0;
    for (int i = 0; i < 300 && !ok_c; i++) begin
      step();
      if (clr_cnt >= clr0 + 2) ok_c = 1;
    end
    c2 = clr_last_cyc;
    ok_b = 0;
    for (int i = 0; i < 20 && !ok_b; i++) begin
      step();
      if (beat_idx > 0) ok_b = 1;
    end
    buf_ready_i = 1'b0;
    wait_done(clr0 + 4, 300, ok_d);
    model_count += 16'd2;
    tests_run += 4;
    if (!ok_c || !ok_b || !ok_d) begin fail_cnt++; $display("FAIL b2b_timeout: got %0b%0b%0b, required 111", ok_c, ok_b, ok_d); end
    if (hdr_cyc - c2 < STL + 1) begin fail_cnt++; $display("FAIL b2b_settle: got header %0d cycles after clr2, required >= %0d", hdr_cyc - c2, STL + 1); end
    if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL b2b_missing: got %0d beats left, required 0", exp_q.size()); end
    if (evt_count_o !== model_count) begin fail_cnt++; $display("FAIL b2b_count: got %0d, required %0d", evt_count_o, model_count); end
  endtask

  task automatic test_reset_mid();
    bit ok_l, ok_b, ok_d;
    int clr0;
    ready_mode = 0;
    fill_mem(0);
    read_buffer_i = 1'b1;
    push_expected(1'b1, model_count);
    clr0 = clr_cnt;
    launch(ok_l);
    ok_b = 0;
    for (int i = 0; i < 100 && !ok_b; i++) begin
      step();
      if (beat_idx >= 30) ok_b = 1;
    end
    #1 rst_n_i = 1'b0;
    #1;
    tests_run += 5;
    if (!ok_l || !ok_b) begin fail_cnt++; $display("FAIL rstmid_reach30: got start=%0b beat30=%0b, required 1 1", ok_l, ok_b); end
    if ({m_valid_o, m_last_o, busy_o, clear_evt_o} !== 4'b0) begin
      fail_cnt++; $display("FAIL rstmid_ctrl: got valid/last/busy/clr=%0b%0b%0b%0b, required 0000", m_valid_o, m_last_o, busy_o, clear_evt_o);
    end
    if (m_dat_o !== 32'd0 || event_rd_addr_o !== 6'd0) begin
      fail_cnt++; $display("FAIL rstmid_dat_addr: got dat=%h addr=%0d, required 0 0", m_dat_o, event_rd_addr_o);
    end
    if (evt_count_o !== 16'd0) begin fail_cnt++; $display("FAIL rstmid_count: got %0d, required 0", evt_count_o); end
    exp_q.delete();
    model_count = '0;
    buf_ready_i = 1'b1;
    repeat (4) step();
    if (clr_cnt != clr0) begin fail_cnt++; $display("FAIL rstmid_no_clear: got %0d clears, required 0", clr_cnt - clr0); end
    push_expected(1'b1, model_count);
    rst_n_i = 1'b1;
    launch(ok_l);
    wait_done(clr0 + 2, 300, ok_d);
    model_count++;
    tests_run += 3;
    if (!ok_l || !ok_d) begin fail_cnt++; $display("FAIL rstmid_rerun_timeout: got %0b%0b, required 11", ok_l, ok_d); end
    if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL rstmid_missing: got %0d beats left, required 0", exp_q.size()); end
    if (evt_count_o !== model_count) begin fail_cnt++; $display("FAIL rstmid_count_after: got %0d, required %0d", evt_count_o, model_count); end
  endtask

  task automatic test_wrap();
    bit ok_l, ok_d;
    int clr0;
    ready_mode = 0;
    @(negedge clk);
    force dut.evt_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.evt_cnt_q;
    step();
    model_count = 16'hFFFF;
    for (int e = 0; e < 2; e++) begin
      fill_mem(0);
      read_buffer_i = 1'b0;
      push_expected(1'b0, model_count);
      clr0 = clr_cnt;
      launch(ok_l);
      wait_done(clr0 + 2, 300, ok_d);
      tests_run += 3;
      if (!ok_l || !ok_d) begin fail_cnt++; $display("FAIL wrap_timeout[%0d]: got %0b%0b, required 11", e, ok_l, ok_d); end
      if (hdr_dat[15:0] !== model_count) begin fail_cnt++; $display("FAIL wrap_header[%0d]: got %h, required %h", e, hdr_dat[15:0], model_count); end
      model_count++;
      if (evt_count_o !== model_count) begin fail_cnt++; $display("FAIL wrap_count[%0d]: got %h, required %h", e, evt_count_o, model_count); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < NW; i++) mem[i] = '0;
    test_reset();
    test_single();
    test_random();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    repeat (5) step();
    tests_run++;
    if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL final_queue: got %0d beats left, required 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt + 1);
    $fatal(1, "timeout");
  end

endmodule
